// File: rtl/sync_fifo.sv
// Single-clock FIFO of any depth, tracking occupancy with a counter so every entry is usable.
// FWFT=0 gives a registered read with 1-cycle latency; FWFT=1 presents the head word combinationally.
module sync_fifo #(
  parameter int FIFO_WIDTH       = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter bit FWFT             = 1'b0,
  parameter int ALMOST_FULL_LVL  = FIFO_DEPTH - 1,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            data_valid,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            underflow
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  empty_s, full_s, rd_acc_s, wr_acc_s;

  always_comb begin
    empty_s  = (count_q == {CW{1'b0}});
    full_s   = (count_q == DEPTH_C);
    rd_acc_s = rd_en & ~empty_s;
    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    wr_acc_s = wr_en & (~full_s | rd_acc_s);

    rd_ptr_d = rd_ptr_q;
    if (rd_acc_s) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? {PW{1'b0}} : rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    wr_ptr_d = wr_ptr_q;
    if (wr_acc_s) begin
      wr_ptr_d = (wr_ptr_q == LAST_C) ? {PW{1'b0}} : wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    dout_d = dout_q;
    if (!FWFT && rd_acc_s) begin
      dout_d = mem_q[rd_ptr_q];
    end else begin
      dout_d = dout_q;
    end
    dvalid_d = FWFT ? 1'b0 : rd_acc_s;
    ovf_d    = wr_en & ~wr_acc_s;
    udf_d    = rd_en & ~rd_acc_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      dout_q   <= {FIFO_WIDTH{1'b0}};
      dvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = FWFT ? mem_q[rd_ptr_q] : dout_q;
  assign data_valid   = FWFT ? ~empty_s : dvalid_q;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (int'(count_q) >= ALMOST_FULL_LVL);
  assign almost_empty = (int'(count_q) <= ALMOST_EMPTY_LVL);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read and an FWFT instance (depth 5) share one
// stimulus stream and are compared against a queue model with a read-data scoreboard.
module tb_sync_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout0, dout1;
  logic       dv0, dv1, full0, full1, empty0, empty1, af0, af1, ae0, ae1;
  logic       ovf0, ovf1, udf0, udf1;
  logic [2:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  logic [7:0] model[$];
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout0), .data_valid(dv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(udf0));

  sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(dout1), .data_valid(dv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input logic ovf_e, input logic udf_e);
    int n;
    n = model.size();
    chk("count0", 32'(cnt0), 32'(n));
    chk("count1", 32'(cnt1), 32'(n));
    chk("full0", 32'(full0), 32'(n == 5));
    chk("full1", 32'(full1), 32'(n == 5));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("afull0", 32'(af0), 32'(n >= 4));
    chk("afull1", 32'(af1), 32'(n >= 4));
    chk("aempty0", 32'(ae0), 32'(n <= 1));
    chk("aempty1", 32'(ae1), 32'(n <= 1));
    chk("ovf0", 32'(ovf0), 32'(ovf_e));
    chk("ovf1", 32'(ovf1), 32'(ovf_e));
    chk("udf0", 32'(udf0), 32'(udf_e));
    chk("udf1", 32'(udf1), 32'(udf_e));
  endtask

  // One clock with the given request; called at posedge+1.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic rd_acc, wr_acc;
    logic [7:0] got;
    wr_en = w; data_in = d; rd_en = r;
    #1;
    chk("fwft_valid", 32'(dv1), 32'(model.size() != 0));
    if (model.size() != 0) chk("fwft_head", 32'(dout1), 32'(model[0]));
    rd_acc = r && (model.size() != 0);
    wr_acc = w && ((model.size() < 5) || rd_acc);
    if (rd_acc) sb.push_back(model.pop_front());
    if (wr_acc) model.push_back(d);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("reg_valid", 32'(dv0), 32'(rd_acc));
    if (dv0) begin
      if (sb.size() == 0) begin
        chk("reg_sb_empty", 32'(1), 32'(0));
      end else begin
        got = sb.pop_front();
        chk("reg_data", 32'(dout0), 32'(got));
      end
    end
    chk_status(w && !wr_acc, r && !rd_acc);
  endtask

  task automatic do_reset(input logic w, input logic r);
    wr_en = w; rd_en = r; data_in = 8'hEE; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    model.delete();
    sb.delete();
    chk("rst_dout0", 32'(dout0), 32'h0);
    chk("rst_dv0", 32'(dv0), 32'h0);
    chk("rst_dv1", 32'(dv1), 32'h0);
    chk_status(1'b0, 1'b0);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(1'b0, 1'b0);

    // Fill to full, overflow on the 6th write, drain, then underflow.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i * 17), 1'b0);
    cycle(1'b1, 8'h66, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Pointer wrap past index 4.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Full with simultaneous read and write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hA1 + i), 1'b0);
    cycle(1'b1, 8'hAB, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);

    // Empty with simultaneous read and write.
    cycle(1'b1, 8'h77, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    // Streaming pop.
    for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Mid-operation reset with concurrent requests.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    do_reset(1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

    // Mixed traffic.
    for (int i = 0; i < 60; i++) cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
